seq_det_param: RTL and testbench

Parametrised, runtime-programmable Mealy serial pattern detector. It consumes one qualified bit per `valid` cycle and flags, in the same cycle, the bit that completes the programmed pattern. Pattern length and overlap mode are selectable at run time, and an optional saturating match counter is available. It sits on serial data front-ends as the generalised successor of the fixed 4-bit "1110" detectors, and covers that case with its reset defaults.

---
 rtl/seq_det_param_if.sv | 40 ++++
 rtl/seq_det_param.sv | 157 +++++++++++++++
 tb/tb_seq_det_param.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_param_if.sv
// Bus bundle for seq_det_param: serial data, runtime configuration and detector outputs.
// match_cnt exists only when SEQ_DET_CNT_EN is defined.
interface seq_det_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("seq_det_param_if: CNT_W must be at least 1");
    end

    logic               valid;
    logic               d_in;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_ovl;
    logic               patt_det;
    logic               armed;
`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    modport master (
        output valid, d_in, cfg_load, cfg_pattern, cfg_len, cfg_ovl,
`ifdef SEQ_DET_CNT_EN
        input  match_cnt,
`endif
        input  patt_det, armed
    );

    modport slave (
        input  valid, d_in, cfg_load, cfg_pattern, cfg_len, cfg_ovl,
`ifdef SEQ_DET_CNT_EN
        output match_cnt,
`endif
        output patt_det, armed
    );
endinterface

// File: rtl/seq_det_param.sv
// Runtime-programmable Mealy serial pattern detector with sliding-window matching.
// Optional saturating match counter built when SEQ_DET_CNT_EN is defined.
module seq_det_param #(
    parameter int                 MAX_LEN  = 8,
    parameter logic [MAX_LEN-1:0] PATT_RST = MAX_LEN'(8'b0000_1110),
    parameter int                 LEN_RST  = 4,
    parameter int                 CNT_W    = 16
) (
    input logic             clk,
    input logic             rst,
    seq_det_param_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int HW = MAX_LEN - 1;
    localparam logic [LW-1:0] LEN_RST_C = LW'(LEN_RST);
    localparam logic [LW-1:0] MAX_LEN_C = LW'(MAX_LEN);
    localparam logic [LW-1:0] ZERO_C    = {LW{1'b0}};
    localparam logic [LW-1:0] ONE_C     = LW'(1);

    if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_max_len_chk
        $error("seq_det_param: MAX_LEN must be in 2..32");
    end
    if (LEN_RST < 1 || LEN_RST > MAX_LEN) begin : g_len_rst_chk
        $error("seq_det_param: LEN_RST must be in 1..MAX_LEN");
    end
    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("seq_det_param: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        DIS   = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    function automatic state_t entry_state(input logic [LW-1:0] l);
        state_t s;
        if (l == ZERO_C) begin
            s = DIS;
        end else if (l == ONE_C) begin
            s = ARMED;
        end else begin
            s = FILL;
        end
        return s;
    endfunction

    state_t             state_r;
    logic [MAX_LEN-1:0] pat_r;
    logic [LW-1:0]      len_r;
    logic               ovl_r;
    logic [HW-1:0]      hist_r;
    logic [LW-1:0]      fill_r;
    logic               armed_r;

    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               match_s;
    logic               patt_det_s;
    logic [LW-1:0]      load_len_s;
    logic [LW-1:0]      fill_inc_s;
    logic [LW-1:0]      len_m1_s;

    // Window compare: only the low len bits of {hist, d_in} take part in the match.
    always_comb begin
        window_s = {hist_r, bus.d_in};
        mask_s   = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_r));
        end
        match_s    = (((window_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
        patt_det_s = (state_r == ARMED) & bus.valid & ~bus.cfg_load & match_s;
        if (bus.cfg_len > MAX_LEN_C) begin
            load_len_s = MAX_LEN_C;
        end else begin
            load_len_s = bus.cfg_len;
        end
        fill_inc_s = fill_r + ONE_C;
        len_m1_s   = len_r - ONE_C;
    end

    // Detector FSM, history shift register and active configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r   <= PATT_RST;
            len_r   <= LEN_RST_C;
            ovl_r   <= 1'b0;
            hist_r  <= {HW{1'b0}};
            fill_r  <= ZERO_C;
            state_r <= entry_state(LEN_RST_C);
            armed_r <= (LEN_RST_C == ONE_C);
        end else if (bus.cfg_load) begin
            pat_r   <= bus.cfg_pattern;
            len_r   <= load_len_s;
            ovl_r   <= bus.cfg_ovl;
            hist_r  <= {HW{1'b0}};
            fill_r  <= ZERO_C;
            state_r <= entry_state(load_len_s);
            armed_r <= (load_len_s == ONE_C);
        end else if (bus.valid) begin
            case (state_r)
                DIS: begin
                    state_r <= DIS;
                    armed_r <= 1'b0;
                end
                FILL: begin
                    hist_r <= window_s[HW-1:0];
                    fill_r <= fill_inc_s;
                    if (fill_inc_s == len_m1_s) begin
                        state_r <= ARMED;
                        armed_r <= 1'b1;
                    end else begin
                        state_r <= FILL;
                        armed_r <= 1'b0;
                    end
                end
                ARMED: begin
                    // Non-overlap mode restarts the window after a hit; otherwise it keeps sliding.
                    if (match_s && !ovl_r) begin
                        hist_r  <= {HW{1'b0}};
                        fill_r  <= ZERO_C;
                        state_r <= entry_state(len_r);
                        armed_r <= (len_r == ONE_C);
                    end else begin
                        hist_r  <= window_s[HW-1:0];
                        state_r <= ARMED;
                        armed_r <= 1'b1;
                    end
                end
                default: begin
                    hist_r  <= {HW{1'b0}};
                    fill_r  <= ZERO_C;
                    state_r <= entry_state(len_r);
                    armed_r <= (len_r == ONE_C);
                end
            endcase
        end
    end

    assign bus.patt_det = patt_det_s;
    assign bus.armed    = armed_r;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Saturating hit counter; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (patt_det_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt_r;
`endif
endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: a bit-list reference model predicts each cycle,
// a monitor pops and compares on the falling edge.
module tb_seq_det_param;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int LEN_RST = 4;
    localparam logic [MAX_LEN-1:0] PATT_RST = 8'b0000_1110;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_det_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) sif ();

    seq_det_param #(
        .MAX_LEN (MAX_LEN),
        .PATT_RST(PATT_RST),
        .LEN_RST (LEN_RST),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    typedef struct {
        logic det;
        logic arm;
        int   cnt;
        int   idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model: configuration plus the list of valid bits since the last clear.
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 m_bits[$];
    int                 m_cnt;

    function automatic void model_reset();
        m_pat = PATT_RST;
        m_len = LEN_RST;
        m_ovl = 1'b0;
        m_bits.delete();
        m_cnt = 0;
    endfunction

    function automatic bit model_armed();
        return (m_len > 0) && (m_bits.size() >= m_len - 1);
    endfunction

    // The last len-1 received bits followed by d must equal the pattern, MSB first.
    function automatic bit model_match(bit d);
        int base;
        if (!model_armed()) return 1'b0;
        base = m_bits.size() - (m_len - 1);
        for (int k = 0; k < m_len - 1; k++) begin
            if (m_bits[base + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return d == m_pat[0];
    endfunction

    task automatic cycle(input bit r, input bit v, input bit d, input bit ld,
                         input logic [MAX_LEN-1:0] p, input int l, input bit o);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        sif.valid       = v;
        sif.d_in        = d;
        sif.cfg_load    = ld;
        sif.cfg_pattern = p;
        sif.cfg_len     = LW'(l);
        sif.cfg_ovl     = o;
        if (r) model_reset();
        e.arm = model_armed();
        e.det = !r && v && !ld && model_match(d);
        e.cnt = m_cnt;
        e.idx = cyc;
        cyc++;
        q.push_back(e);
        if (!r) begin
            if (e.det && m_cnt < CNT_MAX) m_cnt++;
            if (ld) begin
                m_pat = p;
                m_len = (l > MAX_LEN) ? MAX_LEN : l;
                m_ovl = o;
                m_bits.delete();
            end else if (v && m_len > 0) begin
                if (e.det && !m_ovl) begin
                    m_bits.delete();
                end else begin
                    m_bits.push_back(d);
                    if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                end
            end
        end
    endtask

    task automatic bit_in(input bit d);
        cycle(1'b0, 1'b1, d, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic idle(input bit d);
        cycle(1'b0, 1'b0, d, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input int l, input bit o);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, p, l, o);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic send_msb(input logic [MAX_LEN-1:0] p, input int l);
        for (int i = l - 1; i >= 0; i--) bit_in(p[i]);
    endtask

    // Monitor: compare the DUT against the oldest prediction, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (sif.patt_det !== e.det) begin
                    n_err++;
                    $display("FAIL patt_det cyc=%0d got=%b exp=%b", e.idx, sif.patt_det, e.det);
                end
                n_cmp++;
                if (sif.armed !== e.arm) begin
                    n_err++;
                    $display("FAIL armed cyc=%0d got=%b exp=%b", e.idx, sif.armed, e.arm);
                end
`ifdef SEQ_DET_CNT_EN
                n_cmp++;
                if (sif.match_cnt !== CNT_W'(e.cnt)) begin
                    n_err++;
                    $display("FAIL match_cnt cyc=%0d got=%0d exp=%0d", e.idx, sif.match_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sif.valid       = 1'b0;
        sif.d_in        = 1'b0;
        sif.cfg_load    = 1'b0;
        sif.cfg_pattern = '0;
        sif.cfg_len     = '0;
        sif.cfg_ovl     = 1'b0;
        model_reset();

        // Reset defaults: 1110, non-overlap.
        do_reset();
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);

        // Overlap versus non-overlap on 101.
        load(8'b101, 3, 1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        load(8'b101, 3, 1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);

        // Valid gaps with d_in toggling.
        load(8'b1110, 4, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            bit_in(PATT_RST[i]);
            idle(1'b1); idle(1'b0); idle(1'b1);
        end

        // Boundary lengths.
        load(8'b1, 1, 1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        load(8'hA5, 8, 1'b0);
        bit_in(1'b1); bit_in(1'b1);
        send_msb(8'hA5, 8);
        load(8'h00, 0, 1'b0);
        for (int i = 0; i < 10; i++) bit_in(i[0]);
        load(8'h0F, 15, 1'b1);
        send_msb(8'h0F, 8);

        // Collisions: load on the completing bit, then rst mid-pattern.
        load(8'b1110, 4, 1'b0);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'b1110, 4, 1'b0);
        bit_in(1'b0);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
        do_reset();
        bit_in(1'b0);

        // Counter saturation and survival across cfg_load.
        do_reset();
        load(8'b1, 1, 1'b0);
        for (int i = 0; i < 5; i++) bit_in(1'b1);
        load(8'b1110, 4, 1'b1);
        idle(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel == 0) begin
                cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
            end else if (sel < 4) begin
                cycle(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1,
                      MAX_LEN'($urandom), $urandom_range(0, 5) == 0 ? $urandom_range(0, 15)
                                                                     : $urandom_range(1, 4),
                      $urandom_range(0, 1));
            end else begin
                cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), 1'b0,
                      8'h00, 0, 1'b0);
            end
        end

        idle(1'b0);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
